if_prefetch_unit: RTL

- Instruction-fetch front end for the pipelined RV32 core, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word reads to the instruction side of the shared memory port, using a grant-based handshake.
- Buffers returned instructions in a small prefetch queue and presents one {inst, pc, pc+4} per cycle to decode, with a stall input.
- Flushes on a branch/jump redirect resolved later in the pipeline.

---
 rtl/if_pkg.sv | 21 ++
 rtl/prefetch_fifo.sv | 62 ++++++
 rtl/if_prefetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous prefetch queue holding {pc, inst} pairs; flush empties it in one cycle.
module prefetch_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [63:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [63:0]              head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [63:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues granted word reads and feeds decode from a prefetch queue.
module if_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_inc
);

    import if_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_e  state_r;
    fetch_state_e  state_nxt_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [31:0]   last_pc_r;
    logic          inflight_r;
    logic          req_s;
    logic          accept_s;
    logic          rsp_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic [CW-1:0] count_s;
    logic [CW:0]   occupancy_s;
    logic [63:0]   head_s;
    fetch_entry_t  head_e;
    fetch_entry_t  push_e;

    // Outstanding response is reserved a slot so a full queue never has to drop data.
    assign occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
    assign req_s       = rst && (state_r == S_RUN) && !redirect_valid && !full_s
                         && (occupancy_s < (CW+1)'(DEPTH));
    assign accept_s    = req_s && imem_gnt;
    assign rsp_s       = imem_rvalid && inflight_r && !redirect_valid;
    assign pop_s       = !empty_s && id_ready && !redirect_valid;
    assign push_e      = '{pc: rsp_pc_r, inst: imem_rdata};
    assign head_e      = fetch_entry_t'(head_s);

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rsp_s),
        .push_data (push_e),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: a redirect with a response in flight spends one cycle draining it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_RUN:   state_nxt_s = (redirect_valid && (accept_s || inflight_r)) ? S_DRAIN : S_RUN;
            S_DRAIN: state_nxt_s = (redirect_valid && inflight_r) ? S_DRAIN : S_RUN;
            default: state_nxt_s = S_RUN;
        endcase
    end

    // FSM outputs and decode-facing view of the queue head.
    always_comb begin
        imem_req  = req_s;
        imem_addr = fetch_pc_r;
        if_valid  = !empty_s;
        if (empty_s) begin
            if_inst = NOP_INST;
            if_pc   = last_pc_r;
        end else begin
            if_inst = head_e.inst;
            if_pc   = head_e.pc;
        end
        if_pc_inc = if_pc + 32'd4;
    end

    // Fetch PC, in-flight tracking and last presented PC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            rsp_pc_r   <= 32'h0000_0000;
            last_pc_r  <= 32'h0000_0000;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= accept_s;
            if (accept_s) begin
                rsp_pc_r <= fetch_pc_r;
            end
            if (!empty_s) begin
                last_pc_r <= head_e.pc;
            end
            if (redirect_valid) begin
                fetch_pc_r <= word_align(redirect_pc);
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
        end
    end

endmodule
